multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the datapath-map selects (ALU operand A/B source, ALU-op source, destination-register source, PC source) plus write strobes and the memory handshake.
- Sits between the instruction register / ALU compare output and the datapath muxes, register file, PC register and memory port.

Parameters:
- MEM_TIMEOUT, 255: max cycles a memory request (fetch or data) may wait for mem_ready before bus-timeout fault; range 1..65535.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]; valid from DECODE onward, stable until next ir_load
- branch_taken  in  1  ALU comparison result; valid during EXECUTE of OP_BRANCH
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  1 = store, 0 = read
- mem_is_fetch  out  1  address mux: 1 = PC, 0 = ALU result
- ir_load  out  1  capture memory read data into IR
- pc_write  out  1  load PC from source selected by pc_src
- reg_write  out  1  register file write enable
- retire  out  1  one-cycle pulse on the final cycle of each instruction
- alu_in_a  out  1  ALU_IN_A_REG=0 / ALU_IN_A_PC=1
- alu_in_b  out  1  ALU_IN_B_REG=0 / ALU_IN_B_IMM=1
- alu_op_from  out  2  FIXED_ADD=0, ARITHMETIC_FROM_OPCODE=1, LOGIC_FROM_OPCODE=2
- dest_reg_from  out  2  NONE=0, ALU=1, MEM=2, PC=3
- pc_src  out  1  PC_SRC_NEXT_PC=0 / PC_SRC_ALU=1
- fault  out  2  0 none, 1 illegal opcode, 2 bus timeout; sticky
- state  out  3  debug: FETCH=0, DECODE=1, EXECUTE=2, BR_TARGET=3, MEM=4, WRITEBACK=5, TRAP=7

Behaviour:
- Reset (async assert, sync release): state=FETCH, fault=0, timeout counter=0.
- While reset is asserted, all strobes and selects are 0.
- mem_req rises in the first clock after release.
- Reset mid-instruction or mid-request aborts it immediately; no write strobes are emitted.
- Unlisted outputs are 0 in every state. Selects are Moore outputs of (state, opcode).
- FETCH: mem_req=1, mem_is_fetch=1, mem_we=0.
  - On mem_ready: ir_load=1, next DECODE. Otherwise stay.
- DECODE: 1 cycle, register-file read.
  - Opcode not in {ALU, ALUI, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC}: next TRAP, fault=1. Otherwise next EXECUTE.
- EXECUTE selects (a, b, op_from):
  - ALU: REG, REG, ARITH → WRITEBACK
  - ALUI: REG, IMM, ARITH → WRITEBACK
  - LUI: REG (decoder forces rs1=x0), IMM, FIXED_ADD → WRITEBACK
  - AUIPC: PC, IMM, FIXED_ADD → WRITEBACK
  - LOAD/STORE: REG, IMM, FIXED_ADD → MEM
  - JAL: PC, IMM, FIXED_ADD. JALR: REG, IMM, FIXED_ADD. Both in the same cycle: pc_src=ALU, pc_write=1, reg_write=1, dest=PC (link = pre-update next-PC), retire=1 → FETCH
  - BRANCH: REG, REG, LOGIC.
    - branch_taken=0: pc_write=1, pc_src=NEXT_PC, retire=1 → FETCH.
    - branch_taken=1: → BR_TARGET.
- BR_TARGET: PC, IMM, FIXED_ADD, pc_src=ALU, pc_write=1, retire=1 → FETCH.
- MEM: ALU selects held from EXECUTE; mem_req=1, mem_is_fetch=0, mem_we=(opcode==STORE).
  - On mem_ready, LOAD: → WRITEBACK.
  - On mem_ready, STORE: pc_write=1, pc_src=NEXT_PC, retire=1 → FETCH.
- WRITEBACK: selects held from EXECUTE; reg_write=1, pc_write=1, pc_src=NEXT_PC, retire=1 → FETCH.
  - dest: ALU for ALU/ALUI/LUI/AUIPC; MEM for LOAD.
- Timeout counter: 16-bit.
  - Cleared on entry to FETCH/MEM; increments each cycle there without mem_ready.
  - When count reaches MEM_TIMEOUT and mem_ready=0: mem_req drops, → TRAP, fault=2.
  - mem_ready in the same cycle the count reaches the limit completes normally.
- TRAP: all strobes 0, mem_req=0; stays until reset. The first fault wins.
- Cycles per instruction (mem_ready immediate):
  - ALU/ALUI/LUI/AUIPC: 4
  - JAL/JALR: 3
  - BRANCH: 3 not taken, 4 taken
  - STORE: 4
  - LOAD: 5
- Exactly one retire per instruction. pc_write and ir_load never assert in the same cycle.

Test Plan:
- Reset release, mem_ready tied 1, opcode=0110011 (ALU) → states 0,1,2,5 repeating; reg_write and retire in cycle 4 with dest=1, pc_src=0.
- LOAD with mem_ready delayed 3 cycles in MEM → mem_req=1 and mem_we=0 for 4 MEM cycles; WRITEBACK dest=2; 8 cycles from FETCH to retire.
- BRANCH with branch_taken=1 → EXECUTE op_from=2; BR_TARGET a=PC, b=IMM, pc_src=1, pc_write=1. Repeat with taken=0 → pc_write with pc_src=0 in EXECUTE.
- JAL → EXECUTE a=1, b=1, pc_src=1, reg_write=1, dest=3, retire=1 in the same cycle; next state FETCH.
- opcode=1111111 → TRAP after DECODE, fault=1, no strobes for 20 cycles. Separately, MEM_TIMEOUT=4 with mem_ready=0 in FETCH → TRAP after 4 cycles, fault=2.
- Assert rst_n=0 mid-MEM for a STORE → mem_req drops asynchronously, no pc_write; after release state=0 and fault=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives the datapath
// selects, write strobes and the memory handshake.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_is_fetch,
  output logic       ir_load,
  output logic       pc_write,
  output logic       reg_write,
  output logic       retire,
  output logic       alu_in_a,
  output logic       alu_in_b,
  output logic [1:0] alu_op_from,
  output logic [1:0] dest_reg_from,
  output logic       pc_src,
  output logic [1:0] fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_BR_TARGET = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd7
  } state_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [16:0] TMO_LIMIT = 17'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [1:0]  fault_q, fault_d;
  logic [15:0] cnt_q, cnt_d;

  // Per-opcode ALU operand/op selects, shared by EXECUTE, MEM and WRITEBACK
  logic       sel_a, sel_b, legal;
  logic [1:0] sel_op;
  logic [16:0] cnt_inc;
  logic        tmo;

  assign cnt_inc = {1'b0, cnt_q} + 17'd1;
  // The request has waited its full budget if this cycle ends without ready
  assign tmo     = (cnt_inc >= TMO_LIMIT);

  assign state = state_q;
  assign fault = fault_q;

  // Opcode decode: operand sources, ALU-op source and legality
  always_comb begin
    sel_a  = 1'b0;
    sel_b  = 1'b0;
    sel_op = 2'd0;
    legal  = 1'b1;
    case (opcode)
      OP_ALU:             sel_op = 2'd1;
      OP_ALUI:   begin sel_b = 1'b1; sel_op = 2'd1; end
      OP_LUI:             sel_b = 1'b1;
      OP_AUIPC:  begin sel_a = 1'b1; sel_b = 1'b1; end
      OP_LOAD,
      OP_STORE,
      OP_JALR:            sel_b = 1'b1;
      OP_JAL:    begin sel_a = 1'b1; sel_b = 1'b1; end
      OP_BRANCH:          sel_op = 2'd2;
      default:            legal = 1'b0;
    endcase
  end

  // Next-state, fault, timeout counter and Moore/handshake outputs
  always_comb begin
    state_d       = state_q;
    fault_d       = fault_q;
    cnt_d         = '0;   // cleared whenever a wait state is entered or left
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_is_fetch  = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    retire        = 1'b0;
    alu_in_a      = 1'b0;
    alu_in_b      = 1'b0;
    alu_op_from   = 2'd0;
    dest_reg_from = 2'd0;
    pc_src        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req      = 1'b1;
        mem_is_fetch = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          state_d = S_TRAP;
          fault_d = 2'd2;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      S_DECODE: begin
        if (legal) state_d = S_EXECUTE;
        else begin
          state_d = S_TRAP;
          fault_d = 2'd1;
        end
      end
      S_EXECUTE: begin
        alu_in_a    = sel_a;
        alu_in_b    = sel_b;
        alu_op_from = sel_op;
        case (opcode)
          OP_JAL, OP_JALR: begin
            // Link value is the pre-update next-PC, so both writes share a cycle
            pc_src        = 1'b1;
            pc_write      = 1'b1;
            reg_write     = 1'b1;
            dest_reg_from = 2'd3;
            retire        = 1'b1;
            state_d       = S_FETCH;
          end
          OP_BRANCH: begin
            if (branch_taken) state_d = S_BR_TARGET;
            else begin
              pc_write = 1'b1;
              retire   = 1'b1;
              state_d  = S_FETCH;
            end
          end
          OP_LOAD, OP_STORE: state_d = S_MEM;
          default:           state_d = S_WRITEBACK;
        endcase
      end
      S_BR_TARGET: begin
        // ALU reused to form PC + imm once the compare has resolved
        alu_in_a = 1'b1;
        alu_in_b = 1'b1;
        pc_src   = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM: begin
        alu_in_a    = sel_a;
        alu_in_b    = sel_b;
        alu_op_from = sel_op;
        mem_req     = 1'b1;
        mem_we      = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end else if (tmo) begin
          state_d = S_TRAP;
          fault_d = 2'd2;
        end else begin
          cnt_d = cnt_inc[15:0];
        end
      end
      S_WRITEBACK: begin
        alu_in_a      = sel_a;
        alu_in_b      = sel_b;
        alu_op_from   = sel_op;
        reg_write     = 1'b1;
        pc_write      = 1'b1;
        retire        = 1'b1;
        dest_reg_from = (opcode == OP_LOAD) ? 2'd2 : 2'd1;
        state_d       = S_FETCH;
      end
      default: ;  // TRAP: everything quiet until reset
    endcase
    // Asserted reset silences every strobe immediately, aborting any request
    if (!rst_n) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_is_fetch  = 1'b0;
      ir_load       = 1'b0;
      pc_write      = 1'b0;
      reg_write     = 1'b0;
      retire        = 1'b0;
      alu_in_a      = 1'b0;
      alu_in_b      = 1'b0;
      alu_op_from   = 2'd0;
      dest_reg_from = 2'd0;
      pc_src        = 1'b0;
    end
  end

  // State, sticky fault and timeout counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      fault_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class
// cycle by cycle against hand-computed state/strobe values.
module tb_multicycle_control;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken, mem_ready;
  logic       mem_req, mem_we, mem_is_fetch, ir_load, pc_write, reg_write, retire;
  logic       alu_in_a, alu_in_b, pc_src;
  logic [1:0] alu_op_from, dest_reg_from, fault;
  logic [2:0] state;
  logic [13:0] outs;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cyc   = 0;

  always #5 clk = ~clk;

  assign outs = {mem_req, mem_we, mem_is_fetch, ir_load, pc_write, reg_write, retire,
                 alu_in_a, alu_in_b, alu_op_from, dest_reg_from, pc_src};

  multicycle_control #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_load(ir_load), .pc_write(pc_write),
    .reg_write(reg_write), .retire(retire), .alu_in_a(alu_in_a),
    .alu_in_b(alu_in_b), .alu_op_from(alu_op_from), .dest_reg_from(dest_reg_from),
    .pc_src(pc_src), .fault(fault), .state(state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the middle of the next cycle; caller sets inputs then waits #1
  task automatic nxt;
    @(negedge clk);
    n_cyc++;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = OP_ALU; branch_taken = 1'b0;
    #2;
    chk("rst_outs", 32'(outs), 0);
    chk("rst_state", 32'(state), 0);
    chk("rst_fault", 32'(fault), 0);
    mem_ready = 1'b1;
    #1;
    chk("rst_outs_rdy", 32'(outs), 0);

    // ALU: 0,1,2,5 with mem_ready tied high
    nxt; rst_n = 1'b1; #1;
    chk("alu_f_state", 32'(state), 0);
    chk("alu_f_req", 32'({mem_req, mem_is_fetch, mem_we, ir_load}), 32'b1101);
    nxt; #1;
    chk("alu_d_state", 32'(state), 1);
    chk("alu_d_outs", 32'(outs), 0);
    nxt; #1;
    chk("alu_e_state", 32'(state), 2);
    chk("alu_e_sel", 32'({alu_in_a, alu_in_b, alu_op_from}), 32'b0001);
    chk("alu_e_rw", 32'(reg_write), 0);
    nxt; #1;
    chk("alu_w_state", 32'(state), 5);
    chk("alu_w_str", 32'({reg_write, retire, pc_write, pc_src}), 32'b1110);
    chk("alu_w_dest", 32'(dest_reg_from), 1);

    // LOAD with mem_ready held off for 3 MEM cycles (ready on the limit cycle)
    nxt; opcode = OP_LOAD; n_cyc = 1; #1;
    chk("ld_f_state", 32'(state), 0);
    nxt; #1;
    chk("ld_d_state", 32'(state), 1);
    nxt; mem_ready = 1'b0; #1;
    chk("ld_e_sel", 32'({state, alu_in_a, alu_in_b, alu_op_from}), {3'd2, 4'b0100});
    nxt; #1;
    chk("ld_m1", 32'({state, mem_req, mem_we, mem_is_fetch, alu_in_b}), {3'd4, 4'b1001});
    nxt; #1;
    chk("ld_m2", 32'({state, mem_req, retire}), {3'd4, 2'b10});
    nxt; #1;
    chk("ld_m3", 32'({state, mem_req, retire}), {3'd4, 2'b10});
    nxt; mem_ready = 1'b1; #1;
    chk("ld_m4", 32'({state, mem_req, mem_we}), {3'd4, 2'b10});
    nxt; #1;
    chk("ld_w_state", 32'(state), 5);
    chk("ld_w_dest", 32'({dest_reg_from, reg_write, retire}), 32'b1011);
    chk("ld_cycles", 32'(n_cyc), 8);

    // BRANCH taken
    nxt; opcode = OP_BRANCH; #1;
    chk("bt_f_state", 32'(state), 0);
    nxt; #1;
    nxt; branch_taken = 1'b1; #1;
    chk("bt_e", 32'({state, alu_op_from, pc_write, retire}), {3'd2, 2'd2, 2'b00});
    nxt; #1;
    chk("bt_t_state", 32'(state), 3);
    chk("bt_t_str", 32'({alu_in_a, alu_in_b, alu_op_from, pc_src, pc_write, retire}), 32'b1100111);
    nxt; #1;
    chk("bt_next", 32'(state), 0);

    // BRANCH not taken
    nxt; #1;
    nxt; branch_taken = 1'b0; #1;
    chk("bn_e", 32'({state, pc_write, pc_src, retire}), {3'd2, 3'b101});
    nxt; opcode = OP_JAL; #1;
    chk("bn_next", 32'(state), 0);

    // JAL
    nxt; #1;
    nxt; #1;
    chk("jal_e", 32'({state, alu_in_a, alu_in_b, pc_src, pc_write, reg_write, retire}),
        {3'd2, 6'b111111});
    chk("jal_dest", 32'(dest_reg_from), 3);
    nxt; opcode = OP_STORE; #1;
    chk("jal_next", 32'(state), 0);

    // STORE aborted by reset mid-MEM
    nxt; #1;
    nxt; mem_ready = 1'b0; #1;
    nxt; #1;
    chk("st_m", 32'({state, mem_req, mem_we, mem_is_fetch}), {3'd4, 3'b110});
    #2 rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("st_rst_str", 32'({mem_req, pc_write, retire}), 0);
    chk("st_rst_st", 32'({state, fault}), 0);
    nxt; rst_n = 1'b1; opcode = OP_BAD; #1;
    chk("st_rel", 32'({state, fault, mem_req}), 32'b1);

    // Illegal opcode -> TRAP, quiet for 20 cycles
    nxt; #1;
    chk("ill_d", 32'(state), 1);
    nxt; #1;
    chk("ill_trap", 32'({state, fault}), {3'd7, 2'd1});
    for (int i = 0; i < 20; i++) begin
      nxt; #1;
      chk("ill_quiet", 32'({state, fault, outs}), {3'd7, 2'd1, 14'd0});
    end

    // Fetch timeout with MEM_TIMEOUT=4
    nxt; rst_n = 1'b0; #1;
    nxt; rst_n = 1'b1; mem_ready = 1'b0; opcode = OP_ALU; #1;
    chk("tmo_f1", 32'({state, mem_req, fault}), 32'b100);
    for (int i = 2; i <= 4; i++) begin
      nxt; #1;
      chk("tmo_fn", 32'({state, mem_req, fault}), 32'b100);
    end
    nxt; #1;
    chk("tmo_trap", 32'({state, mem_req, fault}), {3'd7, 1'b0, 2'd2});
    mem_ready = 1'b1;
    nxt; #1;
    chk("tmo_sticky", 32'({state, fault, outs}), {3'd7, 2'd2, 14'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
